mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Upstream front-end for the 64x64 iterative `multiplier` block.
- Accepts operand pairs over a valid/ready interface and drives the multiplier's op_start/op_clear/op_done handshake.
- Holds the operands stable for the whole operation, captures the 128-bit result, and presents it on a valid/ready output.
- Frees the host from hand-sequencing op_start and op_clear, and counts completed operations.

Parameters:
- TIMEOUT, 1024: maximum cycles spent in WAIT before abort (used only with MUL_SEQ_TIMEOUT_EN).
- CNT_W, 32: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer can accept an operand pair
- in_multiplier  in  64  operand A
- in_multiplicand  in  64  operand B
- mul_multiplier  out  64  to multiplier.multiplier
- mul_multiplicand  out  64  to multiplier.multiplicand
- mul_op_start  out  1  to multiplier.op_start
- mul_op_clear  out  1  to multiplier.op_clear
- mul_op_done  in  1  from multiplier.op_done
- mul_result  in  128  from multiplier.result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  128  captured product
- out_err  out  1  result aborted by timeout (0 when the feature is compiled out)
- op_count  out  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n. Every register clears on the clk edge where reset_n=0.
- Reset values: state=IDLE; in_ready=1; all mul_* outputs 0; out_valid=0; out_result=0; out_err=0; op_count=0.
- Reset mid-operation aborts immediately. The multiplier is reset by the same reset_n, so no op_clear is issued.
- FSM states: IDLE, START, WAIT, CLEAR, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch both operands into mul_multiplier/mul_multiplicand and go to START.
- START:
  - mul_op_start=1; go to WAIT.
  - Exists so the operands are registered one cycle before start is sampled.
- WAIT:
  - mul_op_start held 1.
  - On an edge with mul_op_done=1, capture mul_result into out_result, set out_err=0, and go to CLEAR.
- CLEAR:
  - mul_op_start=0 and mul_op_clear=1 for exactly one cycle; go to OUT.
  - op_count increments on entry to CLEAR. Timeout aborts count too.
- OUT:
  - out_valid=1 with out_result/out_err stable until out_valid&out_ready; then go to IDLE.
  - mul_op_clear=0.
- Operand hold: mul_multiplier/mul_multiplicand hold their values from acceptance until the next acceptance. They never change while mul_op_start=1.
- in_ready is 0 in every state except IDLE. The design is single-outstanding; there is no acceptance in OUT, even if out_ready=1 in the same cycle.
- Latency:
  - Accept at edge N: mul_op_start=1 from edge N+1.
  - op_done sampled at edge D: mul_op_clear=1 during cycle D+1, out_valid=1 from edge D+2.
  - Minimum accept-to-accept is 4 cycles plus the multiplier time plus output back-pressure.
- mul_op_done asserted outside WAIT is ignored.
- Width rules:
  - Operands and result pass through unmodified.
  - No sign handling here; signedness is the multiplier's concern.

Optional Feature:
- Macro: MUL_SEQ_TIMEOUT_EN.
- Defined:
  - A clog2(TIMEOUT)-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with mul_op_done=0, go to CLEAR, set out_result=0 and out_err=1.
  - mul_op_done on the same edge as the timeout wins: normal capture, out_err=0.
- Undefined:
  - No counter; WAIT has no exit except op_done.
  - out_err is tied to 0.

Decomposition:
- Package mul_seq_pkg:
  - state enum (IDLE, START, WAIT, CLEAR, OUT)
  - OPW=64 and RESW=128 constants
- One sub-module is natural: mul_seq_timer, the WAIT-cycle counter with a terminal-count flag. It is instantiated only under MUL_SEQ_TIMEOUT_EN.
- The FSM and datapath registers stay in the top.

Test Plan:
- Bench model: a behavioural multiplier asserting op_done 3 cycles after op_start and holding it until op_clear.
- Reset: hold reset_n=0 for 2 edges mid-WAIT -> next cycle state IDLE, in_ready=1, mul_op_start=0, op_count=0, out_valid=0.
- Basic: A=5, B=7 with out_ready=1 ->
  - mul_op_start rises 1 cycle after accept;
  - mul_op_clear pulses exactly 1 cycle;
  - out_result=35, out_valid for 1 cycle, op_count=1.
- Back-pressure: A=64'h2d9f9217, B=64'h23cac3, out_ready=0 for 10 cycles ->
  - out_valid and out_result stable throughout;
  - in_ready=0 throughout;
  - accepted on the first out_ready=1 cycle.
- Back-to-back: three pairs (1,1), (2,3), (4753895, -2345 as 64-bit) with in_valid held ->
  - exactly three acceptances;
  - results match the model in order;
  - operands never change while mul_op_start=1;
  - op_count=3.
- Timeout (MUL_SEQ_TIMEOUT_EN, TIMEOUT=16): model never asserts op_done ->
  - out_valid after 16 WAIT cycles plus CLEAR;
  - out_err=1, out_result=0;
  - the next operation completes with out_err=0.
- Stray done: pulse mul_op_done while in IDLE -> no state change, op_count unchanged.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// ============================================================================
// mul_seq_pkg : shared types and widths for the mul_sequencer front-end
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_seq_pkg;

  localparam int OPW  = 64;
  localparam int RESW = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    CLEAR = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mul_seq_timer.sv
// ============================================================================
// mul_seq_timer : WAIT-cycle counter with terminal-count flag at TIMEOUT-1
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_seq_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/mul_sequencer.sv
// ============================================================================
// mul_sequencer : valid/ready front-end sequencing the iterative multiplier's
// op_start/op_clear/op_done handshake. Optional macro: MUL_SEQ_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_multiplier,
  input  logic [OPW-1:0]   in_multiplicand,
  output logic [OPW-1:0]   mul_multiplier,
  output logic [OPW-1:0]   mul_multiplicand,
  output logic             mul_op_start,
  output logic             mul_op_clear,
  input  logic             mul_op_done,
  input  logic [RESW-1:0]  mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RESW-1:0]  out_result,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  state_e            state_q, state_d;
  logic [OPW-1:0]    a_q, a_d;
  logic [OPW-1:0]    b_q, b_d;
  logic [RESW-1:0]   res_q, res_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout;

`ifdef MUL_SEQ_TIMEOUT_EN
  // Clearing during START means the counter reads 0 on the first WAIT cycle.
  mul_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_q == START),
    .en      (state_q == WAIT),
    .tc      (timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_multiplier;
          b_d     = in_multiplicand;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // A done arriving on the timeout edge takes priority over the abort.
        if (mul_op_done) begin
          res_d   = mul_result;
          err_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = CLEAR;
        end else if (timeout) begin
          res_d   = '0;
          err_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = CLEAR;
        end
      end
      CLEAR: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready         = (state_q == IDLE);
  assign mul_op_start     = (state_q == START) || (state_q == WAIT);
  assign mul_op_clear     = (state_q == CLEAR);
  assign out_valid        = (state_q == OUT);
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign out_result       = res_q;
  assign out_err          = err_q;
  assign op_count         = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// ============================================================================
// tb_mul_sequencer : randomized + directed bench for mul_sequencer with a
// behavioural multiplier and a queue-based expected-result model.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mul_sequencer;

  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_multiplier;
  logic [63:0]       in_multiplicand;
  logic [63:0]       mul_multiplier;
  logic [63:0]       mul_multiplicand;
  logic              mul_op_start;
  logic              mul_op_clear;
  logic              mul_op_done;
  logic [127:0]      mul_result;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_result;
  logic              out_err;
  logic [CNT_W-1:0]  op_count;

  always #5 clk = ~clk;

  mul_sequencer #(
    .TIMEOUT (16),
    .CNT_W   (CNT_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplier    (in_multiplier),
    .in_multiplicand  (in_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_op_done      (mul_op_done),
    .mul_result       (mul_result),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_err          (out_err),
    .op_count         (op_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] prod(input logic [63:0] a, input logic [63:0] b);
    return {64'd0, a} * {64'd0, b};
  endfunction

  // Behavioural multiplier: done 3 cycles into op_start, held until op_clear.
  logic         never_done;
  logic         stray_done;
  logic         model_done;
  logic [1:0]   model_cnt;
  logic [127:0] model_res;

  always @(posedge clk) begin
    if (!reset_n || mul_op_clear) begin
      model_done <= 1'b0;
      model_cnt  <= 2'd0;
    end else if (mul_op_start && !never_done && !model_done) begin
      if (model_cnt == 2'd2) model_done <= 1'b1;
      else                   model_cnt  <= model_cnt + 2'd1;
    end
    model_res <= prod(mul_multiplier, mul_multiplicand);
  end

  assign mul_op_done = model_done | stray_done;
  assign mul_result  = model_res;

  // Reference model: expected results in acceptance order.
  typedef struct {
    logic [127:0] res;
    logic         err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pop = 0;
  int          n_acc = 0;
  int          clr_run = 0;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      n_pop   = 0;
      clr_run = 0;
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
`ifdef MUL_SEQ_TIMEOUT_EN
        e.err = never_done;
        e.res = never_done ? 128'd0 : prod(in_multiplier, in_multiplicand);
`else
        e.err = 1'b0;
        e.res = prod(in_multiplier, in_multiplicand);
`endif
        exp_q.push_back(e);
        last_a = in_multiplier;
        last_b = in_multiplicand;
        n_acc++;
      end
      if (mul_op_start) begin
        check_eq("hold_a", mul_multiplier, last_a);
        check_eq("hold_b", mul_multiplicand, last_b);
      end
      if (mul_op_clear) begin
        clr_run++;
      end else if (clr_run != 0) begin
        check_eq("clear_width", clr_run, 1);
        clr_run = 0;
      end
      if (out_valid) check_eq("ready_in_out", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("result", out_result, e.res);
          check_eq("err", out_err, e.err);
          check_eq("op_count", op_count, n_pop + 1);
          n_pop++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    in_valid        = 1'b1;
    in_multiplier   = a;
    in_multiplicand = b;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check_eq("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq("wait_out", out_valid, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pa [3];
    logic [63:0] pb [3];
    logic [127:0] bp_exp;
    int acc0;
    int n;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_multiplier = '0; in_multiplicand = '0;
    never_done = 1'b0; stray_done = 1'b0;
    tick();
    tick();
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_start", mul_op_start, 0);
    check_eq("rst_clear", mul_op_clear, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_result", out_result, 0);
    check_eq("rst_err", out_err, 0);
    check_eq("rst_count", op_count, 0);
    check_eq("rst_ops", {mul_multiplier, mul_multiplicand}, 0);
    reset_n = 1'b1;

    // Reset while parked in WAIT
    never_done = 1'b1;
    send(64'd9, 64'd9);
    tick();
    check_eq("midwait_start", mul_op_start, 1);
    do_reset();
    check_eq("midwait_ready", in_ready, 1);
    check_eq("midwait_start0", mul_op_start, 0);
    check_eq("midwait_count", op_count, 0);
    check_eq("midwait_valid", out_valid, 0);
    never_done = 1'b0;

    // Basic 5 x 7
    out_ready       = 1'b1;
    in_valid        = 1'b1;
    in_multiplier   = 64'd5;
    in_multiplicand = 64'd7;
    check_eq("basic_ready", in_ready, 1);
    check_eq("basic_nostart", mul_op_start, 0);
    tick();
    in_valid = 1'b0;
    check_eq("basic_start_lat", mul_op_start, 1);
    check_eq("basic_a", mul_multiplier, 5);
    check_eq("basic_b", mul_multiplicand, 7);
    wait_out(50);
    check_eq("basic_result", out_result, 35);
    check_eq("basic_err", out_err, 0);
    check_eq("basic_count", op_count, 1);
    tick();
    check_eq("basic_valid_1cyc", out_valid, 0);

    // Back-pressure
    out_ready = 1'b0;
    send(64'h2d9f9217, 64'h23cac3);
    wait_out(50);
    bp_exp = prod(64'h2d9f9217, 64'h23cac3);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_result", out_result, bp_exp);
      check_eq("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    check_eq("bp_valid_last", out_valid, 1);
    tick();
    check_eq("bp_accepted", out_valid, 0);
    check_eq("bp_idle", in_ready, 1);

    // Back-to-back with in_valid held
    do_reset();
    pa[0] = 64'd1;       pb[0] = 64'd1;
    pa[1] = 64'd2;       pb[1] = 64'd3;
    pa[2] = 64'd4753895; pb[2] = -64'd2345;
    acc0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_multiplier   = pa[i];
      in_multiplicand = pb[i];
      n = 0;
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while ((n_pop < 3 || !in_ready) && n < 200) begin
      tick();
      n++;
    end
    check_eq("b2b_acc", n_acc - acc0, 3);
    check_eq("b2b_count", op_count, 3);
    check_eq("b2b_drained", n_pop, 3);

    // Stray done in IDLE
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    check_eq("stray_ready", in_ready, 1);
    check_eq("stray_start", mul_op_start, 0);
    check_eq("stray_valid", out_valid, 0);
    check_eq("stray_count", op_count, 3);

`ifdef MUL_SEQ_TIMEOUT_EN
    // Timeout: 16 WAIT cycles then CLEAR, out_valid 19 edges after accept
    never_done = 1'b1;
    send(64'd3, 64'd4);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check_eq("tmo_latency", n, 18);
    check_eq("tmo_err", out_err, 1);
    check_eq("tmo_result", out_result, 0);
    never_done = 1'b0;
    tick();
    send(64'd6, 64'd7);
    wait_out(50);
    check_eq("tmo_next_err", out_err, 0);
    check_eq("tmo_next_result", out_result, 42);
    tick();
`endif

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid        = ($urandom_range(0, 2) != 0);
      in_multiplier   = {$urandom, $urandom};
      in_multiplicand = {$urandom, $urandom};
      out_ready       = ($urandom_range(0, 1) == 1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      tick();
      n++;
    end
    check_eq("rand_drained", exp_q.size(), 0);
    check_eq("rand_count", op_count, n_pop);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
